reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- 32-entry x 32-bit MIPS register file for the datapath RF stage.
- Consumes the write-back result: one synchronous write port.
- Feeds the ALU/decode stage: two asynchronous read ports (rs, rt).
- Register $0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of architectural registers (2**ADDR_W).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- ra1  input  ADDR_W  read address port 1 (rs).
- ra2  input  ADDR_W  read address port 2 (rt).
- rd1  output  DATA_W  read data port 1.
- rd2  output  DATA_W  read data port 2.
- wa  input  ADDR_W  write address (rd/rt from write-back).
- wd  input  DATA_W  write data.
- we  input  1  write enable.

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: when rst is 1 at a rising clk edge, all 32 registers clear to 0.
  - rst has priority over we in the same cycle.
  - Consequence: rd1 and rd2 read 0 for every address after reset.
- Write:
  - At a rising edge with rst=0, we=1 and wa!=0, register[wa] <= wd.
  - Write latency is 1 cycle: the new value is visible on the read ports after the edge.
  - we=0 leaves all registers unchanged, regardless of wa and wd.
  - A write to wa=0 is silently discarded.
- Read:
  - rd1 = register[ra1] and rd2 = register[ra2], combinational with no clock latency.
  - ra=0 always returns 32'h0.
  - ra1==ra2 is legal; both ports return the same value.
- Same-address read/write in one cycle, without the optional feature: the read ports return the OLD value until the edge, then the new value.
- Reset mid-operation: rst asserted while we=1 discards that write; every register is 0 after the edge.
- X handling: an unknown address with we=0 must not corrupt state.

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN.
- Defined: internal write-through forwarding.
  - If we=1, rst=0, wa!=0 and ra1==wa, then rd1=wd combinationally in the same cycle.
  - The same rule applies independently to rd2.
  - ra=0 still returns 0.
  - This removes the write-back/decode structural hazard without a half-cycle write.
- Undefined: pure array read as in Behaviour; the pipeline must stall or forward externally.

Decomposition:
- Shared package or header (rf_defs): DATA_W, ADDR_W, NUM_REGS, and the constant REG_ZERO=5'd0.
- Natural sub-module: reg_32bits, the existing 32-bit register with data, write-enable, clock and output.
  - Instantiated 31 times via generate, for registers 1..31.
  - Its enable is driven by a one-hot 5-to-32 write decoder gated by we and !rst.
  - Reset clear is done by driving d=0 and we=1 when rst=1.
- Read path: two 32:1 muxes, with index 0 forced to zero.

Test Plan:
- Reset clear: write 32'hDEADBEEF to r5, then assert rst for 1 cycle -> rd1 with ra1=5 reads 0. Apply rst and we=1 (wa=7, wd=9) in the same cycle -> r7 reads 0.
- Basic write/read: we=1, wa=3, wd=4 at the edge near t=6; then wa=3, wd=53 at the next edge; then we=0, wd=6 -> ra1=3 reads 4, then 53, and stays 53 after we drops.
- $0 hardwire: we=1, wa=0, wd=32'hFFFFFFFF -> rd1 and rd2 with ra=0 read 0 forever.
- Dual read: r10=32'h12345678, r31=32'h87654321 -> ra1=10, ra2=31 read both values in the same cycle; ra1=ra2=31 reads 32'h87654321 on both ports.
- Same-cycle read/write on r8 (old value 1), we=1, wa=8, wd=2, ra1=8:
  - Before the edge: rd1 is 1 without RF_WRITE_BYPASS_EN, 2 with it.
  - After the edge: rd1 is 2 in both builds.
- Sweep: write value i*3 to every register 1..31, then read all back via both ports -> each matches, and r0 reads 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared widths and constants for the MIPS register file
package reg_file_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/reg_file_reg_32bits.sv
// reg_32bits: plain enabled register; clearing is done by the caller driving d=0 with we=1
module reg_32bits
    import reg_file_pkg::*;
(
    input  logic              clk,
    input  logic [DATA_W-1:0] d,
    input  logic              we,
    output logic [DATA_W-1:0] q
);
    // load d on any enabled rising edge
    always_ff @(posedge clk)
        if (we) q <= d;
endmodule

// File: rtl/reg_file.sv
// reg_file: 32x32 register file, one sync write port, two async read ports, $0 hardwired to zero; define RF_WRITE_BYPASS_EN for write-through forwarding
module reg_file
    import reg_file_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              we
);
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:1]             en;
    logic [DATA_W-1:0]               d;

    // write decoder: reset enables every register with zero data; otherwise one-hot on wa when we
    always_comb begin
        d = rst ? '0 : wd;
        for (int k = 1; k < NUM_REGS; k++)
            en[k] = rst | (we && wa == ADDR_W'(k));
    end

    assign regs[0] = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        reg_32bits u_reg (
            .clk (clk),
            .d   (d),
            .we  (en[i]),
            .q   (regs[i])
        );
    end

`ifdef RF_WRITE_BYPASS_EN
    logic wr_live;

    // forward the in-flight write-back value to a matching read port; $0 still reads zero
    always_comb begin
        wr_live = we && !rst && wa != REG_ZERO;
        rd1 = (ra1 == REG_ZERO) ? '0 : (wr_live && ra1 == wa) ? wd : regs[ra1];
        rd2 = (ra2 == REG_ZERO) ? '0 : (wr_live && ra2 == wa) ? wd : regs[ra2];
    end
`else
    // pure array read; regs[0] is tied to zero so $0 needs no special case
    always_comb begin
        rd1 = regs[ra1];
        rd2 = regs[ra2];
    end
`endif
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file
module tb_reg_file;
    logic        clk = 0;
    logic        rst, we;
    logic [4:0]  ra1, ra2, wa;
    logic [31:0] rd1, rd2, wd;
    int          passed = 0, total = 0;

    reg_file dut (
        .clk (clk), .rst (rst), .ra1 (ra1), .ra2 (ra2),
        .rd1 (rd1), .rd2 (rd2), .wa (wa), .wd (wd), .we (we)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] v);
        we = 1; wa = a; wd = v;
        tick;
        we = 0;
    endtask

    initial begin
        rst = 1; we = 0; wa = 0; wd = 0; ra1 = 5; ra2 = 7;
        tick;
        rst = 0; #1;
        chk("reset_rd1", rd1, 32'h0);
        chk("reset_rd2", rd2, 32'h0);

        wr(5, 32'hDEADBEEF); #1;
        chk("r5_written", rd1, 32'hDEADBEEF);
        rst = 1; tick; rst = 0; #1;
        chk("r5_cleared", rd1, 32'h0);

        rst = 1; we = 1; wa = 7; wd = 9; tick;
        rst = 0; we = 0; ra1 = 7; #1;
        chk("rst_over_we", rd1, 32'h0);

        ra1 = 3;
        wr(3, 4); #1;
        chk("basic_4", rd1, 32'd4);
        wr(3, 53); #1;
        chk("basic_53", rd1, 32'd53);
        we = 0; wa = 3; wd = 6; tick;
        chk("we0_hold", rd1, 32'd53);

        we = 0; wa = 'x; wd = 32'hA5A5A5A5; tick;
        chk("x_addr_we0", rd1, 32'd53);

        ra1 = 0; ra2 = 0;
        we = 1; wa = 0; wd = 32'hFFFFFFFF; #1;
        chk("r0_pre_rd1", rd1, 32'h0);
        tick; we = 0; #1;
        chk("r0_rd1", rd1, 32'h0);
        chk("r0_rd2", rd2, 32'h0);

        wr(10, 32'h12345678);
        wr(31, 32'h87654321);
        ra1 = 10; ra2 = 31; #1;
        chk("dual_rd1", rd1, 32'h12345678);
        chk("dual_rd2", rd2, 32'h87654321);
        ra1 = 31; #1;
        chk("same_rd1", rd1, 32'h87654321);
        chk("same_rd2", rd2, 32'h87654321);

        wr(8, 1);
        ra1 = 8; ra2 = 10;
        we = 1; wa = 8; wd = 2; #1;
`ifdef RF_WRITE_BYPASS_EN
        chk("rw_pre_edge", rd1, 32'd2);
`else
        chk("rw_pre_edge", rd1, 32'd1);
`endif
        chk("rw_other_port", rd2, 32'h12345678);
        tick; we = 0; #1;
        chk("rw_post_edge", rd1, 32'd2);

        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i * 3));
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i); #1;
            chk($sformatf("sweep_rd1_%0d", i), rd1, 32'(i * 3));
            chk($sformatf("sweep_rd2_%0d", 31 - i), rd2, 32'((31 - i) * 3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
